mem_bus_arbiter: RTL and testbench

//  Shares the single system memory port between the CPU (m0) and the DMA engine (m1).

---
 rtl/bus_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 23 ++
 rtl/bus_watchdog.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// access width codes, the abort read-data pattern and the tie-break rule.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  localparam logic [1:0]  W_BYTE    = 2'd0;
  localparam logic [1:0]  W_HALF    = 2'd1;
  localparam logic [1:0]  W_WORD    = 2'd2;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_DEAD;

  // Winner when both masters request together; round-robin hands it to whoever was not served last.
  function automatic master_e tie_winner(input int round_robin, input master_e last_served);
    if (round_robin == 0) return MST_M1;
    return (last_served == MST_M1) ? MST_M0 : MST_M1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-style port: level read/write request held until ok.
// The requester uses the master modport, the responder the slave modport.
interface mem_bus_arbiter_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  width;
  logic        read;
  logic        write;
  logic [31:0] rdata;
  logic        ok;

  modport master (
    output addr, wdata, width, read, write,
    input  rdata, ok
  );

  modport slave (
    input  addr, wdata, width, read, write,
    output rdata, ok
  );

endinterface

// File: rtl/bus_watchdog.sv
// Counts granted cycles without a memory completion and flags the cycle on
// which the access must be aborted.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic granted,
  input  logic mem_ok,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign timeout = granted && !mem_ok && (count_q == LIMIT);

  // Any ended access (ok or abort) or an idle cycle leaves the count at zero for the next grant.
  always_comb begin
    count_d = count_q + 8'd1;
    if (!granted || mem_ok || timeout) count_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= 8'd0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the system memory port between the CPU (m0) and the DMA engine (m1),
// one registered grant at a time, with a watchdog bounding every access.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int          ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  mem_bus_arbiter_if.slave          m0,
  mem_bus_arbiter_if.slave          m1,
  mem_bus_arbiter_if.master         mem,
  input  logic                      m1_lock,
  output logic                      bus_err,
  output logic [1:0]                grant
);

  arb_state_e  state_q, state_d;
  master_e     last_q, last_d;
  logic        req0, req1;
  logic        granted;
  logic        timeout;
  logic        done;
  logic [31:0] done_rdata;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign granted = (state_q != ST_IDLE);
  assign done    = granted && (mem.ok || timeout);
  assign done_rdata = !done ? 32'd0 : (mem.ok ? mem.rdata : ERR_RDATA);

  assign bus_err = timeout;
  assign grant   = {state_q == ST_G1, state_q == ST_G0};

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .granted (granted),
    .mem_ok  (mem.ok),
    .timeout (timeout)
  );

  // On completion the finishing master's request is stale, so only the other side is considered.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1)
          state_d = (tie_winner(ROUND_ROBIN, last_q) == MST_M1) ? ST_G1 : ST_G0;
        else if (req1)
          state_d = ST_G1;
        else if (req0)
          state_d = ST_G0;
      end
      ST_G0: begin
        if (done) begin
          last_d  = MST_M0;
          state_d = req1 ? ST_G1 : ST_IDLE;
        end else if (!req0) begin
          state_d = ST_IDLE;
        end
      end
      ST_G1: begin
        if (done) begin
          last_d = MST_M1;
          if (m1_lock)   state_d = ST_G1;
          else if (req0) state_d = ST_G0;
          else           state_d = ST_IDLE;
        end else if (!req1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    mem.width = 2'd0;
    mem.read  = 1'b0;
    mem.write = 1'b0;
    m0.ok     = 1'b0;
    m0.rdata  = 32'd0;
    m1.ok     = 1'b0;
    m1.rdata  = 32'd0;
    unique case (state_q)
      ST_G0: begin
        mem.addr  = m0.addr;
        mem.wdata = m0.wdata;
        mem.width = m0.width;
        mem.read  = m0.read & ~m0.write;
        mem.write = m0.write;
        m0.ok     = done;
        m0.rdata  = done_rdata;
      end
      ST_G1: begin
        mem.addr  = m1.addr;
        mem.wdata = m1.wdata;
        mem.width = m1.width;
        mem.read  = m1.read & ~m1.write;
        mem.write = m1.write;
        m1.ok     = done;
        m1.rdata  = done_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      last_q  <= MST_M0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives two arbiters (fixed priority / timeout 4 and round-robin / timeout 6)
// with shared stimulus and compares both against a rule-level model.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  localparam int RR_A  = 0;
  localparam int TMO_A = 4;
  localparam int RR_B  = 1;
  localparam int TMO_B = 6;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        read;
    logic        write;
  } mreq_t;

  typedef struct packed {
    logic [31:0] m0_rdata;
    logic        m0_ok;
    logic [31:0] m1_rdata;
    logic        m1_ok;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        bus_err;
    logic [1:0]  grant;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m1_lock = 1'b0;
  logic        mem_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  mreq_t       drv [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: owner -1 idle / 0 / 1, last served master, granted cycles without ok
  int owner [2] = '{-1, -1};
  int last  [2] = '{0, 0};
  int wdog  [2] = '{0, 0};

  obs_t seen [2];
  obs_t expd [2];
  obs_t obs_a, obs_b;
  logic bus_err_a, bus_err_b;
  logic [1:0] grant_a, grant_b;

  always #5 clk = ~clk;

  mem_bus_arbiter_if a_m0 ();
  mem_bus_arbiter_if a_m1 ();
  mem_bus_arbiter_if a_mem ();
  mem_bus_arbiter_if b_m0 ();
  mem_bus_arbiter_if b_m1 ();
  mem_bus_arbiter_if b_mem ();

  assign a_m0.addr  = drv[0].addr;  assign b_m0.addr  = drv[0].addr;
  assign a_m0.wdata = drv[0].wdata; assign b_m0.wdata = drv[0].wdata;
  assign a_m0.width = drv[0].width; assign b_m0.width = drv[0].width;
  assign a_m0.read  = drv[0].read;  assign b_m0.read  = drv[0].read;
  assign a_m0.write = drv[0].write; assign b_m0.write = drv[0].write;
  assign a_m1.addr  = drv[1].addr;  assign b_m1.addr  = drv[1].addr;
  assign a_m1.wdata = drv[1].wdata; assign b_m1.wdata = drv[1].wdata;
  assign a_m1.width = drv[1].width; assign b_m1.width = drv[1].width;
  assign a_m1.read  = drv[1].read;  assign b_m1.read  = drv[1].read;
  assign a_m1.write = drv[1].write; assign b_m1.write = drv[1].write;
  assign a_mem.ok    = mem_ok;      assign b_mem.ok    = mem_ok;
  assign a_mem.rdata = mem_rdata;   assign b_mem.rdata = mem_rdata;

  assign obs_a = {a_m0.rdata, a_m0.ok, a_m1.rdata, a_m1.ok, a_mem.addr, a_mem.wdata,
                  a_mem.width, a_mem.read, a_mem.write, bus_err_a, grant_a};
  assign obs_b = {b_m0.rdata, b_m0.ok, b_m1.rdata, b_m1.ok, b_mem.addr, b_mem.wdata,
                  b_mem.width, b_mem.read, b_mem.write, bus_err_b, grant_b};

  mem_bus_arbiter #(.ROUND_ROBIN(RR_A), .TIMEOUT(TMO_A)) dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .m0      (a_m0),
    .m1      (a_m1),
    .mem     (a_mem),
    .m1_lock (m1_lock),
    .bus_err (bus_err_a),
    .grant   (grant_a)
  );

  mem_bus_arbiter #(.ROUND_ROBIN(RR_B), .TIMEOUT(TMO_B)) dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .m0      (b_m0),
    .m1      (b_m1),
    .mem     (b_mem),
    .m1_lock (m1_lock),
    .bus_err (bus_err_b),
    .grant   (grant_b)
  );

  function automatic int tmo(int k);
    return (k == 0) ? TMO_A : TMO_B;
  endfunction

  function automatic int rr(int k);
    return (k == 0) ? RR_A : RR_B;
  endfunction

  function automatic bit wants(int m);
    return drv[m].read || drv[m].write;
  endfunction

  function automatic obs_t predict(int k);
    obs_t        o;
    mreq_t       r;
    bit          fin;
    logic [31:0] data;
    o = '0;
    if (owner[k] >= 0) begin
      r    = drv[owner[k]];
      fin  = mem_ok || (wdog[k] == tmo(k) - 1);
      data = fin ? (mem_ok ? mem_rdata : ERR_RDATA) : 32'd0;
      o.mem_addr  = r.addr;
      o.mem_wdata = r.wdata;
      o.mem_width = r.width;
      o.mem_read  = r.read && !r.write;
      o.mem_write = r.write;
      o.bus_err   = !mem_ok && (wdog[k] == tmo(k) - 1);
      if (owner[k] == 0) begin
        o.grant = 2'b01; o.m0_ok = fin; o.m0_rdata = data;
      end else begin
        o.grant = 2'b10; o.m1_ok = fin; o.m1_rdata = data;
      end
    end
    return o;
  endfunction

  function automatic void advanceModel(int k);
    int x;
    bit fin;
    x = owner[k];
    if (!rstn) begin
      owner[k] = -1; last[k] = 0; wdog[k] = 0;
      return;
    end
    fin = (x >= 0) && (mem_ok || (wdog[k] == tmo(k) - 1));
    if (x < 0) begin
      wdog[k] = 0;
      if (wants(0) && wants(1)) owner[k] = (rr(k) == 0) ? 1 : 1 - last[k];
      else if (wants(1))        owner[k] = 1;
      else if (wants(0))        owner[k] = 0;
    end else if (fin) begin
      last[k] = x;
      wdog[k] = 0;
      if (x == 1 && m1_lock)    owner[k] = 1;
      else if (wants(1 - x))    owner[k] = 1 - x;
      else                      owner[k] = -1;
    end else if (!wants(x)) begin
      owner[k] = -1;
      wdog[k]  = 0;
    end else begin
      wdog[k]++;
    end
  endfunction

  task automatic applyStimulus(int m, bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                               logic [1:0] width);
    drv[m] = '{addr: addr, wdata: wdata, width: width, read: rd, write: wr};
  endtask

  // Samples both DUTs mid-cycle, compares with the model, then moves to just after the next edge.
  task automatic checkOutput(string tag);
    obs_t got;
    #3;
    for (int k = 0; k < 2; k++) begin
      expd[k] = predict(k);
      got     = (k == 0) ? obs_a : obs_b;
      seen[k] = got;
      checks++;
      assert (got === expd[k]) else begin
        failures++;
        $error("[TB] FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, k, cyc, got, expd[k]);
      end
    end
    advanceModel(0);
    advanceModel(1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic expectVal(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  initial begin
    bit ok_prev [2];
    int kind;
    drv[0] = '0;
    drv[1] = '0;
    ok_prev = '{0, 0};
    @(posedge clk);
    #1;

    $display("[TB] reset");
    checkOutput("reset");
    expectVal("reset_grant_a", 32'(seen[0].grant), 32'd0);
    expectVal("reset_grant_b", 32'(seen[1].grant), 32'd0);
    rstn = 1'b1;

    $display("[TB] single cpu read");
    applyStimulus(0, 1, 0, 32'h0800_0000, 32'd0, W_WORD);
    checkOutput("t1_req");
    checkOutput("t1_wait1");
    expectVal("t1_grant_a", 32'(seen[0].grant), 32'd1);
    expectVal("t1_grant_b", 32'(seen[1].grant), 32'd1);
    expectVal("t1_memread", 32'(seen[0].mem_read), 32'd1);
    checkOutput("t1_wait2");
    mem_ok = 1'b1; mem_rdata = 32'h1234_5678;
    checkOutput("t1_ok");
    expectVal("t1_m0ok", 32'(seen[0].m0_ok), 32'd1);
    expectVal("t1_m0rdata", seen[0].m0_rdata, 32'h1234_5678);
    expectVal("t1_m1ok", 32'(seen[0].m1_ok), 32'd0);
    mem_ok = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t1_idle");
    expectVal("t1_idle_grant", 32'(seen[0].grant), 32'd0);

    $display("[TB] simultaneous requests");
    applyStimulus(0, 1, 0, 32'h100, 32'd0, W_HALF);
    applyStimulus(1, 1, 0, 32'h200, 32'd0, W_WORD);
    checkOutput("t2_req");
    mem_ok = 1'b1; mem_rdata = 32'hA1;
    checkOutput("t2_m1");
    expectVal("t2_first_grant", 32'(seen[0].grant), 32'd2);
    expectVal("t2_m1ok", 32'(seen[0].m1_ok), 32'd1);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, W_BYTE);
    mem_rdata = 32'hA2;
    checkOutput("t2_m0");
    expectVal("t2_second_grant", 32'(seen[0].grant), 32'd1);
    expectVal("t2_no_bubble", 32'(seen[0].mem_read), 32'd1);
    mem_ok = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t2_idle");

    $display("[TB] round robin alternation");
    applyStimulus(0, 1, 0, 32'h300, 32'd0, W_WORD);
    applyStimulus(1, 1, 0, 32'h400, 32'd0, W_WORD);
    checkOutput("t3_req");
    mem_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'(i);
      checkOutput("t3_acc");
      expectVal("t3_order", 32'(seen[1].grant), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    mem_ok = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t3_drop");
    expectVal("t3_drop_read", 32'(seen[1].mem_read), 32'd0);
    checkOutput("t3_idle");
    expectVal("t3_abandon_idle", 32'(seen[1].grant), 32'd0);

    $display("[TB] dma lock");
    m1_lock = 1'b1;
    applyStimulus(1, 0, 1, 32'h500, 32'hCAFE_0001, W_WORD);
    applyStimulus(0, 1, 0, 32'h600, 32'd0, W_WORD);
    checkOutput("t4_req");
    mem_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m1_lock = 1'b0;
      drv[1].wdata = 32'hCAFE_0001 + 32'(i);
      checkOutput("t4_dma");
      expectVal("t4_locked_grant", 32'(seen[0].grant), 32'd2);
      expectVal("t4_cpu_waits", 32'(seen[0].m0_ok), 32'd0);
    end
    applyStimulus(1, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t4_cpu");
    expectVal("t4_cpu_grant", 32'(seen[0].grant), 32'd1);
    mem_ok = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t4_idle");

    $display("[TB] watchdog");
    applyStimulus(0, 1, 0, 32'h700, 32'd0, W_WORD);
    checkOutput("t5_req");
    checkOutput("t5_wait");
    checkOutput("t5_wait");
    checkOutput("t5_wait");
    expectVal("t5_no_err_early", 32'(seen[0].bus_err), 32'd0);
    checkOutput("t5_abort");
    expectVal("t5_m0ok", 32'(seen[0].m0_ok), 32'd1);
    expectVal("t5_rdata", seen[0].m0_rdata, 32'hDEAD_DEAD);
    expectVal("t5_bus_err", 32'(seen[0].bus_err), 32'd1);
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t5_after");
    expectVal("t5_idle", 32'(seen[0].grant), 32'd0);
    checkOutput("t5_idle_b");

    $display("[TB] reset mid access");
    applyStimulus(1, 1, 0, 32'h800, 32'd0, W_WORD);
    checkOutput("t6_req");
    applyStimulus(0, 1, 0, 32'h900, 32'd0, W_WORD);
    rstn = 1'b0;
    checkOutput("t6_g1");
    expectVal("t6_g1_grant", 32'(seen[0].grant), 32'd2);
    rstn = 1'b1;
    applyStimulus(1, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t6_rst");
    expectVal("t6_rst_grant", 32'(seen[0].grant), 32'd0);
    expectVal("t6_rst_read", 32'(seen[0].mem_read), 32'd0);
    checkOutput("t6_regrant");
    expectVal("t6_regrant_a", 32'(seen[0].grant), 32'd1);
    expectVal("t6_regrant_b", 32'(seen[1].grant), 32'd1);
    mem_ok = 1'b1;
    checkOutput("t6_ok");
    mem_ok = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 32'd0, W_BYTE);
    checkOutput("t6_idle");

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (wants(m)) begin
          if (ok_prev[m] || $urandom_range(0, 49) == 0)
            applyStimulus(m, 0, 0, 32'd0, 32'd0, W_BYTE);
        end else if ($urandom_range(0, 2) == 0) begin
          kind = int'($urandom_range(0, 15));
          applyStimulus(m, (kind < 8) || (kind == 15), kind >= 8, $urandom, $urandom,
                        2'($urandom_range(0, 2)));
        end
      end
      m1_lock   = ($urandom_range(0, 5) == 0);
      mem_ok    = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      checkOutput("rand");
      ok_prev[0] = expd[0].m0_ok;
      ok_prev[1] = expd[0].m1_ok;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
